// File: rtl/bbox_pkg.sv
// bbox_pkg: shared types, widths and helpers for the bounding-box detector
// and the raster counter it shares with the cropping stage.
//   state_t             : detector FSM states
//   coord_t             : pixel coordinate (COORD_W bits)
//   expand_lo/expand_hi : widen a bound by a margin, clamped to the frame
package bbox_pkg;

  localparam int COORD_W = 11;
  localparam int ADDR_W  = 24;
  localparam int SUM_W   = 10;
  localparam int EXT_W   = COORD_W + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_CAP,
    S_EVAL,
    S_FINAL,
    S_DONE
  } state_t;

  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [EXT_W-1:0]   ext_t;

  // Lower bound minus margin. The extra top bit catches the borrow, so a
  // would-be negative result saturates at 0 instead of wrapping.
  function automatic coord_t expand_lo(input coord_t v, input int margin);
    ext_t t;
    t = {1'b0, v} - ext_t'(margin);
    return t[EXT_W-1] ? '0 : t[COORD_W-1:0];
  endfunction

  // Upper bound plus margin, saturating at the last valid coordinate.
  function automatic coord_t expand_hi(input coord_t v, input int margin,
                                       input coord_t limit);
    ext_t t;
    t = {1'b0, v} + ext_t'(margin);
    return (t > {1'b0, limit}) ? limit : t[COORD_W-1:0];
  endfunction

endpackage

// File: rtl/bbox_raster_counter.sv
// raster_counter: walks a WIDTH x HEIGHT frame in raster order with three
// byte channels per pixel (channel innermost, then x, then y).
//   clk, rst : clock, synchronous active-high reset
//   clear    : restart from (0,0) channel 0
//   step_c   : advance channel; holds at the last channel
//   step_px  : move to the next pixel, channel back to 0, wraps at frame end
//   x, y, c  : current position
//   last_c, last_x, last_px : on last channel / last column / last pixel
module raster_counter
  import bbox_pkg::*;
#(
  parameter int WIDTH  = 100,
  parameter int HEIGHT = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       step_c,
  input  logic       step_px,
  output coord_t     x,
  output coord_t     y,
  output logic [1:0] c,
  output logic       last_c,
  output logic       last_x,
  output logic       last_px
);

  assign last_c  = (c == 2'd2);
  assign last_x  = (x == COORD_W'(WIDTH - 1));
  assign last_px = last_x && (y == COORD_W'(HEIGHT - 1));

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would make results depend on block order.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      x <= '0;
      y <= '0;
      c <= '0;
    end else if (step_px) begin
      c <= '0;
      if (last_x) begin
        x <= '0;
        y <= last_px ? '0 : y + COORD_W'(1);
      end else begin
        x <= x + COORD_W'(1);
      end
    end else if (step_c && !last_c) begin
      c <= c + 2'd1;
    end
  end

endmodule

// File: rtl/bbox_detect.sv
// bbox_detect: scans a packed 24-bit RGB frame, classifies pixels as
// foreground when R+G+B < THRESH, and reports the inclusive bounding box of
// all foreground pixels (widened by MARGIN, clamped to the frame).
//   clk, rst               : clock, synchronous active-high reset
//   start                  : begin a scan (honoured only in IDLE or DONE)
//   done                   : high while results are valid
//   found                  : last scan saw at least one foreground pixel
//   readAddr               : byte address to image memory
//   readdata               : memory data, [7:0] valid one cycle after readAddr
//   xMin, xMax, yMin, yMax : inclusive box; full frame when nothing found
module bbox_detect
  import bbox_pkg::*;
#(
  parameter int WIDTH    = 100,
  parameter int HEIGHT   = 100,
  parameter int PIX_BASE = 0,
  parameter int THRESH   = 384,
  parameter int MARGIN   = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              done,
  output logic              found,
  output logic [ADDR_W-1:0] readAddr,
  input  logic [15:0]       readdata,
  output coord_t            xMin,
  output coord_t            xMax,
  output coord_t            yMin,
  output coord_t            yMax
);

  localparam logic [SUM_W-1:0]  THRESH_V = SUM_W'(THRESH);
  localparam logic [ADDR_W-1:0] BASE_V   = ADDR_W'(PIX_BASE);
  localparam coord_t            X_LAST   = COORD_W'(WIDTH - 1);
  localparam coord_t            Y_LAST   = COORD_W'(HEIGHT - 1);

  state_t           state;
  logic [SUM_W-1:0] sum;
  logic             hit;
  coord_t           run_xmin, run_xmax, run_ymin, run_ymax;

  coord_t     x, y;
  logic [1:0] c;
  logic       last_c, last_px;
  logic       unused_last_x;
  logic       unused_hi;
  logic       launch;

  // Only the low byte carries pixel data.
  assign unused_hi = ^readdata[15:8];

  assign launch = start && ((state == S_IDLE) || (state == S_DONE));

  raster_counter #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT)
  ) u_raster (
    .clk     (clk),
    .rst     (rst),
    .clear   (launch),
    .step_c  (state == S_CAP),
    .step_px (state == S_EVAL),
    .x       (x),
    .y       (y),
    .c       (c),
    .last_c  (last_c),
    .last_x  (unused_last_x),
    .last_px (last_px)
  );

  // The frame is packed with no row padding, so the byte address is just a
  // linear count from PIX_BASE that steps after every captured channel.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      done     <= 1'b0;
      found    <= 1'b0;
      readAddr <= BASE_V;
      xMin     <= '0;
      xMax     <= '0;
      yMin     <= '0;
      yMax     <= '0;
      sum      <= '0;
      hit      <= 1'b0;
      run_xmin <= '1;
      run_xmax <= '0;
      run_ymin <= '1;
      run_ymax <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state    <= S_REQ;
            done     <= 1'b0;
            readAddr <= BASE_V;
            sum      <= '0;
            hit      <= 1'b0;
            run_xmin <= '1;
            run_xmax <= '0;
            run_ymin <= '1;
            run_ymax <= '0;
          end
        end
        S_REQ: state <= S_CAP;
        S_CAP: begin
          sum      <= sum + SUM_W'(readdata[7:0]);
          readAddr <= readAddr + ADDR_W'(1);
          state    <= last_c ? S_EVAL : S_REQ;
        end
        S_EVAL: begin
          if (sum < THRESH_V) begin
            hit <= 1'b1;
            if (x < run_xmin) run_xmin <= x;
            if (x > run_xmax) run_xmax <= x;
            if (y < run_ymin) run_ymin <= y;
            if (y > run_ymax) run_ymax <= y;
          end
          sum   <= '0;
          state <= last_px ? S_FINAL : S_REQ;
        end
        S_FINAL: begin
          if (hit) begin
            xMin <= expand_lo(run_xmin, MARGIN);
            xMax <= expand_hi(run_xmax, MARGIN, X_LAST);
            yMin <= expand_lo(run_ymin, MARGIN);
            yMax <= expand_hi(run_ymax, MARGIN, Y_LAST);
          end else begin
            xMin <= '0;
            xMax <= X_LAST;
            yMin <= '0;
            yMax <= Y_LAST;
          end
          found <= hit;
          done  <= 1'b1;
          state <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bbox_detect.sv
// tb_bbox_detect: two detectors (MARGIN 0 at base 0, MARGIN 1 at base 100)
// scan the same 4x3 frame from a shared byte-memory model. Each table entry
// places up to two special pixels in an all-0xFF frame and gives the expected
// box for both margins.
`timescale 1ns/1ps
module tb_bbox_detect;
  import bbox_pkg::*;

  localparam int W     = 4;
  localparam int H     = 3;
  localparam int NB    = W * H * 3;
  localparam int BASE0 = 0;
  localparam int BASE1 = 100;
  localparam int SCAN  = 7 * W * H;
  localparam int NV    = 7;

  typedef struct packed {
    logic [10:0] xmin;
    logic [10:0] xmax;
    logic [10:0] ymin;
    logic [10:0] ymax;
  } box_t;

  typedef struct {
    int          n;
    int          x0, y0;
    logic [23:0] c0;
    int          x1, y1;
    logic [23:0] c1;
    logic        fnd;
    box_t        m0;
    box_t        m1;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        done0, found0, done1, found1;
  logic [23:0] addr0, addr1;
  logic [15:0] rd0 = '0, rd1 = '0;
  logic [10:0] xmin0, xmax0, ymin0, ymax0;
  logic [10:0] xmin1, xmax1, ymin1, ymax1;

  logic [7:0] mem [NB];
  vec_t       vecs [NV];
  box_t       prev0, prev1;
  logic       prev_found;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  bbox_detect #(.WIDTH(W), .HEIGHT(H), .PIX_BASE(BASE0), .THRESH(384), .MARGIN(0)) dut0 (
    .clk(clk), .rst(rst), .start(start), .done(done0), .found(found0),
    .readAddr(addr0), .readdata(rd0),
    .xMin(xmin0), .xMax(xmax0), .yMin(ymin0), .yMax(ymax0)
  );

  bbox_detect #(.WIDTH(W), .HEIGHT(H), .PIX_BASE(BASE1), .THRESH(384), .MARGIN(1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .done(done1), .found(found1),
    .readAddr(addr1), .readdata(rd1),
    .xMin(xmin1), .xMax(xmax1), .yMin(ymin1), .yMax(ymax1)
  );

  function automatic logic [7:0] fetch(input logic [23:0] a, input int base);
    int idx;
    idx = int'(a) - base;
    if (idx >= 0 && idx < NB) return mem[idx];
    return 8'h00;
  endfunction

  // One-cycle read latency; the upper byte carries junk the DUT must ignore.
  always @(posedge clk) begin
    rd0 <= {8'hA5, fetch(addr0, BASE0)};
    rd1 <= {8'h5A, fetch(addr1, BASE1)};
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic box_t mkb(input int a, input int b, input int c, input int d);
    box_t r;
    r.xmin = 11'(a);
    r.xmax = 11'(b);
    r.ymin = 11'(c);
    r.ymax = 11'(d);
    return r;
  endfunction

  function automatic box_t cur0();
    return {xmin0, xmax0, ymin0, ymax0};
  endfunction

  function automatic box_t cur1();
    return {xmin1, xmax1, ymin1, ymax1};
  endfunction

  task automatic put_px(input int x, input int y, input logic [23:0] rgb);
    int b;
    b = 3 * (y * W + x);
    mem[b]     = rgb[23:16];
    mem[b + 1] = rgb[15:8];
    mem[b + 2] = rgb[7:0];
  endtask

  task automatic load_frame(input vec_t v);
    for (int i = 0; i < NB; i++) mem[i] = 8'hFF;
    if (v.n > 0) put_px(v.x0, v.y0, v.c0);
    if (v.n > 1) put_px(v.x1, v.y1, v.c1);
  endtask

  // Start a scan and follow it cycle by cycle until done. While scanning,
  // readAddr must walk base, base+1, ... and the previous results must hold.
  // With poke set, a stray start is driven mid-scan and must be ignored.
  task automatic run_scan(input vec_t v, input string tag, input bit poke);
    int   cyc;
    int   k;
    bit   addr_ok;
    bit   hold_ok;
    load_frame(v);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start   = 1'b0;
    cyc     = 1;
    addr_ok = 1'b1;
    hold_ok = 1'b1;
    while (done0 !== 1'b1 && cyc < 200) begin
      if (cyc <= SCAN) begin
        k = cyc - 1;
        if (k % 7 < 6) begin
          if (addr0 !== 24'(BASE0 + 3 * (k / 7) + (k % 7) / 2)) addr_ok = 1'b0;
          if (addr1 !== 24'(BASE1 + 3 * (k / 7) + (k % 7) / 2)) addr_ok = 1'b0;
        end
      end
      if (cur0() !== prev0 || cur1() !== prev1 || found0 !== prev_found ||
          found1 !== prev_found || done1 !== 1'b0)
        hold_ok = 1'b0;
      start = (poke && cyc == 40);
      @(posedge clk);
      #1;
      cyc++;
    end
    start = 1'b0;
    check({tag, " latency"}, 64'(cyc), 64'(SCAN + 2));
    check({tag, " addr_seq"}, 64'(addr_ok), 64'd1);
    check({tag, " hold_old"}, 64'(hold_ok), 64'd1);
    check({tag, " done1"}, 64'(done1), 64'd1);
    check({tag, " found_m0"}, 64'(found0), 64'(v.fnd));
    check({tag, " found_m1"}, 64'(found1), 64'(v.fnd));
    check({tag, " box_m0"}, 64'(cur0()), 64'(v.m0));
    check({tag, " box_m1"}, 64'(cur1()), 64'(v.m1));
    prev0      = v.m0;
    prev1      = v.m1;
    prev_found = v.fnd;
  endtask

  initial begin
    box_t full;
    full = mkb(0, 3, 0, 2);
    //            n  x0 y0 c0           x1 y1 c1           fnd   margin 0          margin 1
    vecs[0] = '{0, 0, 0, 24'h000000, 0, 0, 24'h000000, 1'b0, full,             full};
    vecs[1] = '{1, 2, 1, 24'h000000, 0, 0, 24'h000000, 1'b1, mkb(2, 2, 1, 1), mkb(1, 3, 0, 2)};
    vecs[2] = '{2, 0, 0, 24'h000000, 3, 2, 24'h000000, 1'b1, full,             full};
    vecs[3] = '{1, 1, 1, 24'h000000, 0, 0, 24'h000000, 1'b1, mkb(1, 1, 1, 1), mkb(0, 2, 0, 2)};
    vecs[4] = '{1, 1, 0, 24'h808080, 0, 0, 24'h000000, 1'b0, full,             full};
    vecs[5] = '{1, 1, 0, 24'h80807F, 0, 0, 24'h000000, 1'b1, mkb(1, 1, 0, 0), mkb(0, 2, 0, 1)};
    vecs[6] = '{2, 3, 1, 24'h000000, 2, 2, 24'h80807F, 1'b1, mkb(2, 3, 1, 2), mkb(1, 3, 0, 2)};

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst done", 64'({done0, done1}), 64'd0);
    check("rst found", 64'({found0, found1}), 64'd0);
    check("rst addr0", 64'(addr0), 64'(BASE0));
    check("rst addr1", 64'(addr1), 64'(BASE1));
    check("rst box", 64'({cur0(), cur1()}), 64'd0);
    @(negedge clk);
    rst        = 1'b0;
    prev0      = '0;
    prev1      = '0;
    prev_found = 1'b0;

    // Back-to-back scans, each restarted from DONE with a new frame.
    for (int i = 0; i < NV; i++)
      run_scan(vecs[i], $sformatf("vec%0d", i), (i == 3));

    // Reset in the middle of a scan, then a fresh scan from IDLE.
    load_frame(vecs[1]);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 0; i < 29; i++) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst done", 64'({done0, done1}), 64'd0);
    check("midrst found", 64'({found0, found1}), 64'd0);
    check("midrst addr0", 64'(addr0), 64'(BASE0));
    check("midrst addr1", 64'(addr1), 64'(BASE1));
    check("midrst box", 64'({cur0(), cur1()}), 64'd0);
    @(negedge clk);
    rst        = 1'b0;
    prev0      = '0;
    prev1      = '0;
    prev_found = 1'b0;
    run_scan(vecs[1], "post_rst", 1'b0);

    // Results stay frozen in DONE with start low.
    repeat (5) @(posedge clk);
    #1;
    check("done hold", 64'({done0, found0, cur0()}), 64'({1'b1, 1'b1, vecs[1].m0}));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
